// File: rtl/game_pkg.sv
// Shared types and defaults for the game-flow controller.
// State encoding 6 is used only when GAME_FSM_PAUSE_EN is defined.
package game_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    WLCM  = 3'd1,
    CH    = 3'd2,
    GAME  = 3'd3,
    WL    = 3'd4,
    PA    = 3'd5,
    PAUSE = 3'd6
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOST = 2'b01;
  localparam logic [1:0] RES_WON  = 2'b10;

  localparam int DEF_KEY_PWR   = 10;
  localparam int DEF_KEY_START = 13;
  localparam int DEF_KEY_YES   = 15;
  localparam int DEF_KEY_NO    = 14;
  localparam int DEF_KEY_PAUSE = 12;

  // Only 01 and 10 are real outcomes; 00/11 mean the game is still running.
  function automatic logic res_valid(input logic [1:0] w);
    return (w == RES_LOST) || (w == RES_WON);
  endfunction

endpackage

// File: rtl/game_fsm_ctrl_if.sv
// Keypad/status inputs and state/timer outputs of the game-flow controller.
// master = keypad decoder + game datapath side, slave = controller.
interface game_fsm_ctrl_if #(
  parameter int KEY_W = 5,
  parameter int CNT_W = 8
);
  import game_pkg::*;

  logic             keypad_pressed;
  logic [KEY_W-1:0] key;
  logic [1:0]       W_or_L;
  state_t           presente;
  logic             state_chg;
  logic [1:0]       result;
  logic             tick;
  logic [CNT_W-1:0] ticks_in_state;

  modport master (
    output keypad_pressed, key, W_or_L,
    input  presente, state_chg, result, tick, ticks_in_state
  );

  modport slave (
    input  keypad_pressed, key, W_or_L,
    output presente, state_chg, result, tick, ticks_in_state
  );
endinterface

// File: rtl/game_fsm_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
  parameter int CLK_HZ  = 27000000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == CW'(DIV - 1));
  assign tick   = w_term;

  // divider count, wraps at the terminal value
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_term) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/game_fsm_ctrl.sv
// Game-flow controller: OFF/WLCM/CH/GAME/WL/PA driven by keypad edges and
// hold/timeout timers on a shared tick counter.
// Optional: GAME_FSM_PAUSE_EN adds a PAUSE state that freezes the counter.
module game_fsm_ctrl
  import game_pkg::*;
#(
`ifdef GAME_FSM_PAUSE_EN
  parameter int KEY_PAUSE   = DEF_KEY_PAUSE,
`endif
  parameter int CLK_HZ      = 27000000,
  parameter int TICK_HZ     = 1,
  parameter int KEY_W       = 5,
  parameter int KEY_PWR     = DEF_KEY_PWR,
  parameter int KEY_START   = DEF_KEY_START,
  parameter int KEY_YES     = DEF_KEY_YES,
  parameter int KEY_NO      = DEF_KEY_NO,
  parameter int RESULT_HOLD = 3,
  parameter int WL_HOLD     = 10,
  parameter int PA_TIMEOUT  = 15,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  game_fsm_ctrl_if.slave  bus
);
  state_t           r_state, w_nxt;
  logic             r_prev, r_chg;
  logic [1:0]       r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick, w_evt, w_valid, w_pause_hop;
  logic             w_k_pwr, w_k_start, w_k_yes, w_k_no;

  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  // one action per press: rising edge of the held level only
  assign w_evt     = bus.keypad_pressed & ~r_prev;
  assign w_valid   = res_valid(bus.W_or_L);
  assign w_k_pwr   = w_evt && (bus.key == KEY_W'(KEY_PWR));
  assign w_k_start = w_evt && (bus.key == KEY_W'(KEY_START));
  assign w_k_yes   = w_evt && (bus.key == KEY_W'(KEY_YES));
  assign w_k_no    = w_evt && (bus.key == KEY_W'(KEY_NO));

`ifdef GAME_FSM_PAUSE_EN
  logic w_k_pause;
  assign w_k_pause   = w_evt && (bus.key == KEY_W'(KEY_PAUSE));
  assign w_pause_hop = ((r_state == GAME) && (w_nxt == PAUSE)) ||
                       ((r_state == PAUSE) && (w_nxt == GAME));
`else
  assign w_pause_hop = 1'b0;
`endif

  // next state: key actions first, timer transitions only in the final else
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      OFF:  if (w_k_pwr) w_nxt = WLCM;
      WLCM: if (w_k_pwr) w_nxt = OFF;
            else if (w_k_start) w_nxt = CH;
      CH:   if (w_k_pwr) w_nxt = OFF;
            else if (w_k_start) w_nxt = GAME;
      GAME: if (w_k_pwr) w_nxt = OFF;
`ifdef GAME_FSM_PAUSE_EN
            else if (w_k_pause) w_nxt = PAUSE;
`endif
            else if (w_valid && (r_cnt == CNT_W'(RESULT_HOLD))) w_nxt = WL;
      WL:   if (w_k_pwr) w_nxt = OFF;
            else if (r_cnt == CNT_W'(WL_HOLD)) w_nxt = PA;
      PA:   if (w_k_pwr) w_nxt = OFF;
            else if (w_k_yes) w_nxt = GAME;
            else if (w_k_no) w_nxt = WLCM;
            else if ((PA_TIMEOUT != 0) && (r_cnt == CNT_W'(PA_TIMEOUT))) w_nxt = WLCM;
`ifdef GAME_FSM_PAUSE_EN
      PAUSE: if (w_k_pwr) w_nxt = OFF;
             else if (w_k_pause) w_nxt = GAME;
`endif
      default: w_nxt = OFF;
    endcase
  end

  // state register, change strobe and key-edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OFF;
      r_chg   <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_chg   <= (w_nxt != r_state);
      r_prev  <= bus.keypad_pressed;
    end
  end

  // result latch: captured leaving GAME for WL, cleared on a fresh GAME entry
  always_ff @(posedge clk) begin
    if (rst)
      r_res <= RES_NONE;
    else if ((r_state == GAME) && (w_nxt == WL))
      r_res <= bus.W_or_L;
    else if ((w_nxt == GAME) && ((r_state == CH) || (r_state == PA)))
      r_res <= RES_NONE;
  end

  // shared tick counter; in GAME it only runs while a result is presented
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_nxt != r_state)
      r_cnt <= w_pause_hop ? r_cnt : '0;
    else if ((r_state == GAME) && !w_valid)
      r_cnt <= '0;
    else if (w_tick && (r_state != PAUSE) && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign bus.presente       = r_state;
  assign bus.state_chg      = r_chg;
  assign bus.result         = r_res;
  assign bus.tick           = w_tick;
  assign bus.ticks_in_state = r_cnt;
endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Self-checking bench: two controllers (PA timeout 15 and 0) on shared stimulus,
// compared every cycle against a behavioural model, plus scenario checks.
module tb_game_fsm_ctrl;
  import game_pkg::*;

`ifdef GAME_FSM_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kp  = 1'b0;
  logic [4:0] key = '0;
  logic [1:0] wl  = '0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  game_fsm_ctrl_if #(.KEY_W(5), .CNT_W(8)) bus0 ();
  game_fsm_ctrl_if #(.KEY_W(5), .CNT_W(8)) bus1 ();

  assign bus0.keypad_pressed = kp;
  assign bus0.key            = key;
  assign bus0.W_or_L         = wl;
  assign bus1.keypad_pressed = kp;
  assign bus1.key            = key;
  assign bus1.W_or_L         = wl;

  game_fsm_ctrl #(.CLK_HZ(4), .TICK_HZ(1), .PA_TIMEOUT(15)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  game_fsm_ctrl #(.CLK_HZ(4), .TICK_HZ(1), .PA_TIMEOUT(0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int st; int cnt; int res; int prev; int div; int chg;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, int to, logic r, logic kpi, int k, int w);
    mdl_t n;
    bit tk, evt, valid, hop;
    n = m;
    if (r) begin
      n = '{0, 0, 0, 0, 0, 0};
      return n;
    end
    tk    = (m.div == 3);
    n.div = (m.div + 1) % 4;
    evt   = kpi && !m.prev;
    n.prev = int'(kpi);
    valid = (w == 1) || (w == 2);
    if (!(m.st <= 5 || (PAUSE_EN && m.st == 6))) n.st = 0;
    else if (evt) begin
      if (k == 10)                           n.st = (m.st == 0) ? 1 : 0;
      else if (k == 13 && m.st == 1)         n.st = 2;
      else if (k == 13 && m.st == 2)         n.st = 3;
      else if (k == 15 && m.st == 5)         n.st = 3;
      else if (k == 14 && m.st == 5)         n.st = 1;
      else if (PAUSE_EN && k == 12 && m.st == 3) n.st = 6;
      else if (PAUSE_EN && k == 12 && m.st == 6) n.st = 3;
    end
    if (n.st == m.st) begin
      if (m.st == 3 && valid && m.cnt == 3)    n.st = 4;
      else if (m.st == 4 && m.cnt == 10)       n.st = 5;
      else if (m.st == 5 && to != 0 && m.cnt == to) n.st = 1;
    end
    n.chg = (n.st != m.st) ? 1 : 0;
    hop = (m.st == 3 && n.st == 6) || (m.st == 6 && n.st == 3);
    if (n.chg != 0)             n.cnt = hop ? m.cnt : 0;
    else if (m.st == 3 && !valid) n.cnt = 0;
    else if (tk && m.st != 6)   n.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
    if (m.st == 3 && n.st == 4) n.res = w;
    else if (n.st == 3 && (m.st == 2 || m.st == 5)) n.res = 0;
    return n;
  endfunction

  function automatic logic [14:0] pk(mdl_t m);
    return {3'(m.st), 1'(m.chg), 2'(m.res), (m.div == 3), 8'(m.cnt)};
  endfunction

  // model advances on every edge; outputs compared just after it
  initial begin
    m0 = '{0, 0, 0, 0, 0, 0};
    m1 = '{0, 0, 0, 0, 0, 0};
    forever begin
      @(posedge clk);
      m0 = step(m0, 15, rst, kp, int'(key), int'(wl));
      m1 = step(m1, 0,  rst, kp, int'(key), int'(wl));
      #1;
      chk("dut0_cyc", {bus0.presente, bus0.state_chg, bus0.result, bus0.tick,
                       bus0.ticks_in_state}, pk(m0));
      chk("dut1_cyc", {bus1.presente, bus1.state_chg, bus1.result, bus1.tick,
                       bus1.ticks_in_state}, pk(m1));
    end
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    key = 5'(k); kp = 1'b1;
    @(negedge clk);
    kp = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_st(input int s, input int budget, input string tag);
    int b = 0;
    while (int'(bus0.presente) != s && b < budget) begin
      @(negedge clk); b++;
    end
    chk(tag, bus0.presente, s);
  endtask

  task automatic wait_cnt(input int c, input int budget);
    int b = 0;
    while (int'(bus0.ticks_in_state) != c && b < budget) begin
      @(negedge clk); b++;
    end
  endtask

  task automatic ticks_until(input int s, output int nt);
    int b = 0;
    nt = 0;
    while (int'(bus0.presente) != s && b < 300) begin
      if (bus0.presente == GAME && bus0.tick) nt++;
      @(negedge clk); b++;
    end
  endtask

  task automatic to_game();
    wait_st(int'(WLCM), 1, "at_wlcm");
    press(13);
    press(13);
    chk("in_game", bus0.presente, GAME);
  endtask

  int keys [8] = '{10, 13, 13, 15, 14, 12, 3, 13};

  initial begin
    int pulses, nt, hold, gap;
    // reset and power on
    cyc(2);
    rst = 1'b0;
    chk("rst_st", bus0.presente, OFF);
    chk("rst_cnt", bus0.ticks_in_state, 0);
    key = 5'd10; kp = 1'b1; pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) chk("pwr_on", bus0.presente, WLCM);
      pulses += int'(bus0.state_chg);
    end
    chk("pwr_pulses", pulses, 1);
    chk("pwr_hold", bus0.presente, WLCM);
    kp = 1'b0;
    cyc(1);

    // start to win
    to_game();
    wl = RES_WON;
    wait_st(int'(WL), 100, "win_wl");
    chk("win_res", bus0.result, RES_WON);
    wait_st(int'(PA), 100, "win_pa");

    // YES back into GAME, then a glitchy lost result
    wl = RES_LOST;
    press(15);
    chk("yes_st", bus0.presente, GAME);
    chk("yes_res", bus0.result, RES_NONE);
    wait_cnt(2, 50);
    wl = RES_NONE;
    cyc(1);
    wl = RES_LOST;
    ticks_until(int'(WL), nt);
    chk("glitch_ticks", nt, 3);
    chk("glitch_res", bus0.result, RES_LOST);

    // NO from PA
    wait_st(int'(PA), 100, "pa_again");
    press(14);
    chk("no_st", bus0.presente, WLCM);

    // PA timeout on dut0, no timeout on dut1
    to_game();
    wl = RES_WON;
    wait_st(int'(PA), 200, "pa_reach");
    wl = RES_NONE;
    wait_st(int'(WLCM), 200, "pa_tmo");
    for (int i = 0; i < 110; i++) wait_cnt(-1, 4);
    chk("pa_hold", bus1.presente, PA);
    press(14);
    chk("pa_no1", bus1.presente, WLCM);

    // power key on the same edge WL hits its hold
    to_game();
    wl = RES_WON;
    wait_st(int'(WL), 100, "coll_wl");
    wait_cnt(10, 100);
    press(10);
    chk("coll_off", bus0.presente, OFF);

    // reset mid-GAME; pause key is a no-op without the pause feature
    press(10);
    to_game();
    wl = RES_NONE;
    if (!PAUSE_EN) begin
      press(12);
      chk("pause_ign", bus0.presente, GAME);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_game_st", bus0.presente, OFF);
    chk("rst_game_res", bus0.result, RES_NONE);

`ifdef GAME_FSM_PAUSE_EN
    press(10);
    to_game();
    wl = RES_WON;
    wait_cnt(2, 50);
    press(12);
    chk("pause_st", bus0.presente, PAUSE);
    for (int i = 0; i < 80; i++) @(negedge clk);
    chk("pause_frz", bus0.ticks_in_state, 2);
    press(12);
    ticks_until(int'(WL), nt);
    chk("pause_resume", nt, 1);
`endif

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) wl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1; cyc(1); rst = 1'b0;
      end
      hold = $urandom_range(1, 5);
      gap  = $urandom_range(0, 4);
      key = 5'(keys[$urandom_range(0, 7)]);
      kp = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) key = 5'($urandom_range(0, 31));
      end
      kp = 1'b0;
      repeat (gap + 1 + $urandom_range(0, 12)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
